regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Writeback arbiter and scoreboard for the 8-bit register file (7 GPRs a0-a3,v0,c0,zero; 6 labels l0-l5).
//   Shares the single register-file write port between NREQ producers (ALU, load unit, ...) round-robin.
//   Tracks in-flight GPR writes so issue can stall on RAW/WAW, and sequences pipeline flush (drain).
//   Sits between execute/memory stages and register_file write inputs.
// PARAMETERS
//   NREQ      2   number of writeback requesters (2..4)
//   NUM_GPR   7   general registers tracked by scoreboard (index 7 = illegal)
//   NUM_LBL   6   label registers (index 6,7 = illegal)
// PORTS
//   clk            in   1        system clock; all state updates on posedge
//   rst_n          in   1        synchronous reset, active-low
//   wb_valid_i     in   NREQ     requester i has a write pending
//   wb_ready_o     out  NREQ     requester i granted this cycle (one-hot or zero)
//   wb_rd_i        in   3*NREQ   destination index, requester i at [3i+:3]
//   wb_data_i      in   8*NREQ   write data, requester i at [8i+:8]
//   wb_cond_i      in   NREQ     condition bit accompanying a GPR write
//   wb_label_i     in   NREQ     1 = label-register write, 0 = GPR write
//   rsv_valid_i    in   1        issue stage reserves GPR rsv_rd_i
//   rsv_rd_i       in   3        GPR being reserved
//   chk_rs1_i      in   3        source 1 of instruction in issue
//   chk_rs2_i      in   3        source 2 of instruction in issue
//   hazard_o       out  1        busy[chk_rs1_i] | busy[chk_rs2_i] (combinational)
//   flush_i        in   1        request drain of all outstanding writes
//   flush_done_o   out  1        one-cycle pulse when drain completes
//   rd_o           out  3        to register file rd
//   write_data_o   out  8        to register file write_data
//   condition_bit_o out 1        to register file condition_bit
//   reg_write_o    out  1        to register file reg_write (1-cycle pulse)
//   label_write_o  out  1        to register file label_write (1-cycle pulse)
//   err_o          out  1        sticky: illegal destination index was dropped
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): all outputs 0, busy=0, rr pointer=0, state=RUN, err_o=0.
//   Arbitration: comb; grant first valid requester starting at rr pointer; wb_ready_o=grant.
//     Accept = valid&ready. Pointer <= granted index+1 (mod NREQ) on accept, else unchanged.
//   Write port: outputs registered; accept in cycle N -> rd_o/write_data_o/cond + one strobe high in cycle N+1.
//     Register file samples on the following negedge (half-cycle later). No accept -> both strobes 0.
//     GPR: reg_write_o=1, label_write_o=0. Label: label_write_o=1, reg_write_o=0. Never both.
//   Illegal dest (GPR rd=7, label rd>=6): accepted (ready high), no strobe, err_o<=1 until reset.
//   Scoreboard busy[NUM_GPR-1:0]: set on rsv_valid_i, cleared on accepted GPR write to rd.
//     Updates visible next cycle. Same-cycle set+clear same index: set wins. rsv_rd_i=7 ignored.
//     Reserve of already-busy reg: stays set (no counting); issue must stall on hazard for WAW.
//     hazard_o: index 7 contributes 0. Label writes never touch busy.
//   FSM RUN/DRAIN/DONE:
//     RUN:   arbitrate, accept reservations; flush_i=1 -> DRAIN.
//     DRAIN: rsv_valid_i ignored; arbitration continues; busy==0 and no wb_valid_i -> DONE.
//     DONE:  flush_done_o=1 for exactly this cycle -> RUN. flush_i in DRAIN/DONE ignored.
//   Reset mid-DRAIN: returns to RUN, no flush_done_o pulse, pending strobe cancelled.
// CONFIGURATION
//   REGFILE_WB_STATS_EN defined: adds out port stats_o [16*(NREQ+1)]: per-requester grant counts
//     and conflict count (cycles with >=2 valid), 16-bit saturating at 16'hFFFF, zeroed on reset.
//   Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//   Package regfile_pkg: NUM_GPR, NUM_LBL, GPR_ZERO/V0/C0 index constants, wb_req_t struct
//     {label,rd,data,cond}, wb_state_e enum {RUN,DRAIN,DONE}.
//   Sub-module rr_arbiter (NREQ param: req, advance -> one-hot grant, owns pointer).
// TESTING
//   1 Reset then idle: outputs 0, hazard_o=0, wb_ready_o=0 for 3 cycles.
//   2 Both valid every cycle, A rd=1 d=8'h11, B rd=2 d=8'h22: strobes alternate A,B,A; rd_o 1,2,1.
//   3 rsv rd=3; next cycle chk_rs1=3 -> hazard_o=1; GPR write rd=3 accepted -> hazard_o=0 next cycle.
//   4 Label write rd=5 d=8'hA5 -> label_write_o=1, reg_write_o=0; label rd=6 -> no strobe, err_o=1.
//   5 Same-cycle rsv rd=2 and accepted write rd=2 -> busy[2] remains 1.
//   6 busy={1,4}, flush_i: rsv ignored; after both writes, flush_done_o 1-cycle pulse, state RUN.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

   localparam int unsigned NUM_GPR = 7;
   localparam int unsigned NUM_LBL = 6;
   localparam int unsigned RD_W    = 3;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned STAT_W  = 16;
   localparam int unsigned IDX_N   = 1 << RD_W;

   localparam logic [RD_W-1:0] GPR_V0   = 3'd4;
   localparam logic [RD_W-1:0] GPR_C0   = 3'd5;
   localparam logic [RD_W-1:0] GPR_ZERO = 3'd6;

   typedef struct packed {
      logic              label;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
      logic              cond;
   } wb_req_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } wb_state_e;

   // True when rd addresses an existing register of the selected file.
   function automatic logic dest_legal(input logic label, input logic [RD_W-1:0] rd);
      return label ? (32'(rd) < NUM_LBL) : (32'(rd) < NUM_GPR);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            advance_i,
   output logic [NREQ-1:0] grant_o
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_gidx;
   logic          w_found;
   logic [31:0]   w_idx;

   // Scan requesters starting at the pointer, first hit wins.
   always_comb begin
      grant_o = '0;
      w_gidx  = r_ptr;
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_idx = (32'(r_ptr) + k) % NREQ;
         if (!w_found && req_i[w_idx[PW-1:0]]) begin
            w_found                 = 1'b1;
            w_gidx                  = PW'(w_idx);
            grant_o[w_idx[PW-1:0]]  = 1'b1;
         end
      end
   end

   // Pointer moves just past the winner on every accepted grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (advance_i) begin
         r_ptr <= PW'((32'(w_gidx) + 32'd1) % NREQ);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter, GPR scoreboard and flush sequencer for the 8-bit register file.
// Optional: define REGFILE_WB_STATS_EN to add stats_o grant/conflict counters.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        wb_valid_i,
   output logic [NREQ-1:0]        wb_ready_o,
   input  logic [RD_W*NREQ-1:0]   wb_rd_i,
   input  logic [DATA_W*NREQ-1:0] wb_data_i,
   input  logic [NREQ-1:0]        wb_cond_i,
   input  logic [NREQ-1:0]        wb_label_i,
   input  logic                   rsv_valid_i,
   input  logic [RD_W-1:0]        rsv_rd_i,
   input  logic [RD_W-1:0]        chk_rs1_i,
   input  logic [RD_W-1:0]        chk_rs2_i,
   output logic                   hazard_o,
   input  logic                   flush_i,
   output logic                   flush_done_o,
   output logic [RD_W-1:0]        rd_o,
   output logic [DATA_W-1:0]      write_data_o,
   output logic                   condition_bit_o,
   output logic                   reg_write_o,
   output logic                   label_write_o,
   output logic                   err_o
`ifdef REGFILE_WB_STATS_EN
   ,
   output logic [STAT_W*(NREQ+1)-1:0] stats_o
`endif
);

   logic [NREQ-1:0]    w_grant;
   logic               w_accept;
   logic               w_legal;
   wb_req_t            w_sel;
   logic [IDX_N-1:0]   w_busy_ext;
   logic [IDX_N-1:0]   w_busy_nxt;
   wb_state_e          r_state, w_state_nxt;
   logic [NUM_GPR-1:0] r_busy;
   logic [RD_W-1:0]    r_rd;
   logic [DATA_W-1:0]  r_data;
   logic               r_cond, r_reg_write, r_label_write, r_err, r_flush_done;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (wb_valid_i),
      .advance_i (w_accept),
      .grant_o   (w_grant)
   );

   assign wb_ready_o = w_grant;
   assign w_accept   = |(wb_valid_i & w_grant);

   // Route the granted requester's payload onto the shared write port.
   always_comb begin
      w_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel.label = wb_label_i[i];
            w_sel.rd    = wb_rd_i[RD_W*i +: RD_W];
            w_sel.data  = wb_data_i[DATA_W*i +: DATA_W];
            w_sel.cond  = wb_cond_i[i];
         end
      end
   end

   assign w_legal    = dest_legal(w_sel.label, w_sel.rd);
   assign w_busy_ext = IDX_N'(r_busy);
   assign hazard_o   = w_busy_ext[chk_rs1_i] | w_busy_ext[chk_rs2_i];

   // Scoreboard update: retire first, then reserve so a same-cycle reserve wins.
   always_comb begin
      w_busy_nxt = w_busy_ext;
      if (w_accept && w_legal && !w_sel.label) w_busy_nxt[w_sel.rd] = 1'b0;
      if (rsv_valid_i && (r_state == RUN) && (32'(rsv_rd_i) < NUM_GPR))
         w_busy_nxt[rsv_rd_i] = 1'b1;
   end

   // Flush sequencing: drain outstanding writes, then pulse done for one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (flush_i) w_state_nxt = DRAIN;
         DRAIN:   if ((r_busy == '0) && (wb_valid_i == '0)) w_state_nxt = DONE;
         DONE:    w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // State, scoreboard and registered register-file write port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_busy        <= '0;
         r_rd          <= '0;
         r_data        <= '0;
         r_cond        <= 1'b0;
         r_reg_write   <= 1'b0;
         r_label_write <= 1'b0;
         r_err         <= 1'b0;
         r_flush_done  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_busy        <= w_busy_nxt[NUM_GPR-1:0];
         r_flush_done  <= (w_state_nxt == DONE);
         r_reg_write   <= w_accept & w_legal & ~w_sel.label;
         r_label_write <= w_accept & w_legal & w_sel.label;
         if (w_accept && w_legal) begin
            r_rd   <= w_sel.rd;
            r_data <= w_sel.data;
            r_cond <= w_sel.cond;
         end
         if (w_accept && !w_legal) r_err <= 1'b1;
      end
   end

   assign rd_o            = r_rd;
   assign write_data_o    = r_data;
   assign condition_bit_o = r_cond;
   assign reg_write_o     = r_reg_write;
   assign label_write_o   = r_label_write;
   assign err_o           = r_err;
   assign flush_done_o    = r_flush_done;

`ifdef REGFILE_WB_STATS_EN
   logic [STAT_W-1:0] r_stat [NREQ+1];

   // Saturating per-requester grant counters plus a contention counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i <= NREQ; i++) r_stat[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (wb_valid_i[i] && w_grant[i] && (r_stat[i] != '1))
               r_stat[i] <= r_stat[i] + STAT_W'(1);
         end
         if (($countones(wb_valid_i) >= 2) && (r_stat[NREQ] != '1))
            r_stat[NREQ] <= r_stat[NREQ] + STAT_W'(1);
      end
   end

   // Flatten counters onto the stats bus.
   always_comb begin
      stats_o = '0;
      for (int unsigned i = 0; i <= NREQ; i++) stats_o[STAT_W*i +: STAT_W] = r_stat[i];
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (default build, NREQ=2).
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int NREQ = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NREQ-1:0]  wb_valid_i, wb_ready_o, wb_cond_i, wb_label_i;
   logic [3*NREQ-1:0] wb_rd_i;
   logic [8*NREQ-1:0] wb_data_i;
   logic             rsv_valid_i, hazard_o, flush_i, flush_done_o;
   logic [2:0]       rsv_rd_i, chk_rs1_i, chk_rs2_i, rd_o;
   logic [7:0]       write_data_o;
   logic             condition_bit_o, reg_write_o, label_write_o, err_o;

   logic [2:0] rdv [NREQ];
   logic [7:0] dat [NREQ];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         wb_rd_i[3*i +: 3]   = rdv[i];
         wb_data_i[8*i +: 8] = dat[i];
      end
   end

   regfile_wb_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_rd_i(wb_rd_i),
      .wb_data_i(wb_data_i), .wb_cond_i(wb_cond_i), .wb_label_i(wb_label_i),
      .rsv_valid_i(rsv_valid_i), .rsv_rd_i(rsv_rd_i),
      .chk_rs1_i(chk_rs1_i), .chk_rs2_i(chk_rs2_i), .hazard_o(hazard_o),
      .flush_i(flush_i), .flush_done_o(flush_done_o),
      .rd_o(rd_o), .write_data_o(write_data_o), .condition_bit_o(condition_bit_o),
      .reg_write_o(reg_write_o), .label_write_o(label_write_o), .err_o(err_o)
   );

   typedef struct {
      int         due;
      logic       label;
      logic [2:0] rd;
      logic [7:0] data;
      logic       cond;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         m_ptr;
   int         m_state;
   logic [6:0] m_busy;
   logic       m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic idle();
      wb_valid_i = '0; wb_cond_i = '0; wb_label_i = '0;
      for (int i = 0; i < NREQ; i++) begin rdv[i] = '0; dat[i] = '0; end
      rsv_valid_i = 1'b0; rsv_rd_i = '0;
      chk_rs1_i = '0; chk_rs2_i = '0; flush_i = 1'b0;
   endtask

   task automatic set_req(input int i, input logic lbl, input logic [2:0] rd,
                          input logic [7:0] d, input logic c);
      wb_valid_i[i] = 1'b1; wb_label_i[i] = lbl; rdv[i] = rd; dat[i] = d; wb_cond_i[i] = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ptr = 0; m_busy = '0; m_state = 0; m_err = 1'b0;
      q.delete();
   endtask

   // One clock: compare outputs at negedge against the model, then advance the model.
   task automatic cycle();
      logic [NREQ-1:0] eg;
      int              gi;
      logic [7:0]      bx;
      logic [6:0]      nb;
      logic            legal;
      exp_t            e;
      @(negedge clk);
      eg = '0; gi = -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (gi < 0 && wb_valid_i[idx]) begin gi = idx; eg[idx] = 1'b1; end
      end
      bx = {1'b0, m_busy};
      check("ready", 32'(wb_ready_o), 32'(eg));
      check("hazard", 32'(hazard_o), 32'(bx[chk_rs1_i] | bx[chk_rs2_i]));
      check("flush_done", 32'(flush_done_o), 32'(m_state == 2));
      check("err", 32'(err_o), 32'(m_err));
      if (flush_done_o) done_cnt++;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         check("reg_write", 32'(reg_write_o), 32'(!e.label));
         check("label_write", 32'(label_write_o), 32'(e.label));
         check("rd", 32'(rd_o), 32'(e.rd));
         check("data", 32'(write_data_o), 32'(e.data));
         if (!e.label) check("cond", 32'(condition_bit_o), 32'(e.cond));
      end else begin
         check("reg_write_idle", 32'(reg_write_o), 32'(0));
         check("label_write_idle", 32'(label_write_o), 32'(0));
      end
      nb = m_busy;
      if (gi >= 0) begin
         legal = wb_label_i[gi] ? (rdv[gi] < 3'd6) : (rdv[gi] < 3'd7);
         m_ptr = (gi + 1) % NREQ;
         if (legal) begin
            e.due = cyc + 1; e.label = wb_label_i[gi]; e.rd = rdv[gi];
            e.data = dat[gi]; e.cond = wb_cond_i[gi];
            q.push_back(e);
            if (!wb_label_i[gi]) nb[rdv[gi]] = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end
      if (rsv_valid_i && m_state == 0 && rsv_rd_i != 3'd7) nb[rsv_rd_i] = 1'b1;
      case (m_state)
         0: if (flush_i) m_state = 1;
         1: if (m_busy == '0 && wb_valid_i == '0) m_state = 2;
         default: m_state = 0;
      endcase
      m_busy = nb;
      cyc++;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      @(posedge clk); #1;
      do_reset();

      // 1: idle after reset
      repeat (3) cycle();

      // 2: both requesters every cycle alternate
      set_req(0, 1'b0, 3'd1, 8'h11, 1'b1);
      set_req(1, 1'b0, 3'd2, 8'h22, 1'b0);
      repeat (3) cycle();
      idle();
      cycle();

      // 3: reserve, hazard, retire
      rsv_valid_i = 1'b1; rsv_rd_i = 3'd3; chk_rs1_i = 3'd3;
      cycle();
      rsv_valid_i = 1'b0;
      check("t3_hazard_set", 32'(hazard_o), 32'(1));
      cycle();
      set_req(0, 1'b0, 3'd3, 8'h33, 1'b1);
      cycle();
      idle(); chk_rs1_i = 3'd3; #1;
      check("t3_hazard_clr", 32'(hazard_o), 32'(0));
      cycle();

      // 4: label write and illegal label index
      set_req(1, 1'b1, 3'd5, 8'hA5, 1'b0);
      cycle();
      idle();
      set_req(1, 1'b1, 3'd6, 8'h66, 1'b0);
      cycle();
      idle();
      cycle();
      check("t4_err", 32'(err_o), 32'(1));

      // 5: same-cycle reserve and retire of rd 2, set wins
      rsv_valid_i = 1'b1; rsv_rd_i = 3'd2;
      set_req(0, 1'b0, 3'd2, 8'h02, 1'b0);
      cycle();
      idle(); chk_rs2_i = 3'd2; #1;
      check("t5_busy2", 32'(hazard_o), 32'(1));
      set_req(1, 1'b0, 3'd2, 8'h12, 1'b1);
      cycle();
      idle();
      cycle();

      // reserve of index 7 is ignored, hazard on 7 reads 0
      rsv_valid_i = 1'b1; rsv_rd_i = 3'd7; chk_rs1_i = 3'd7;
      cycle();
      rsv_valid_i = 1'b0;
      cycle();

      // 6: flush drains busy {1,4}; reserve during drain ignored
      done_cnt = 0;
      rsv_valid_i = 1'b1; rsv_rd_i = 3'd1; cycle();
      rsv_rd_i = 3'd4; cycle();
      rsv_valid_i = 1'b0; flush_i = 1'b1; cycle();
      flush_i = 1'b0; rsv_valid_i = 1'b1; rsv_rd_i = 3'd5; chk_rs1_i = 3'd5;
      set_req(0, 1'b0, 3'd1, 8'hB1, 1'b1);
      cycle();
      idle(); chk_rs1_i = 3'd5;
      set_req(1, 1'b0, 3'd4, 8'hB4, 1'b0);
      cycle();
      idle(); chk_rs1_i = 3'd5;
      for (int n = 0; n < 8 && done_cnt == 0; n++) cycle();
      check("t6_done_pulses", 32'(done_cnt), 32'(1));
      cycle();
      check("t6_done_pulses_after", 32'(done_cnt), 32'(1));
      check("t6_rsv5_ignored", 32'(hazard_o), 32'(0));
      rsv_valid_i = 1'b1; rsv_rd_i = 3'd6; chk_rs2_i = 3'd6;
      cycle();
      rsv_valid_i = 1'b0;
      check("t6_back_in_run", 32'(hazard_o), 32'(1));
      cycle();

      // reset in the middle of a drain with a write in flight
      set_req(0, 1'b0, 3'd0, 8'hC0, 1'b1);
      flush_i = 1'b1;
      cycle();
      idle();
      set_req(1, 1'b0, 3'd6, 8'hC6, 1'b0);
      cycle();
      do_reset();
      done_cnt = 0;
      repeat (3) cycle();
      check("rst_drain_no_done", 32'(done_cnt), 32'(0));

      // randomised traffic through the same model
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 2) != 0)
               set_req(i, 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                       8'($urandom), 1'($urandom));
         end
         rsv_valid_i = 1'($urandom_range(0, 2) == 0);
         rsv_rd_i    = 3'($urandom_range(0, 7));
         chk_rs1_i   = 3'($urandom_range(0, 7));
         chk_rs2_i   = 3'($urandom_range(0, 7));
         flush_i     = 1'($urandom_range(0, 19) == 0);
         cycle();
      end
      idle();
      repeat (3) cycle();
      check("queue_empty", 32'(q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
